// File: rtl/pong_match_fsm.sv
// Match sequencer for the pong engine: menu, serve, rally, point, pause and game-over flow.
// Define WIN_BY_TWO_EN to require a two-point lead over every other player to win.
module pong_match_fsm #(
  parameter int NUM_PLAYERS        = 2,
  parameter int SCORE_W            = 4,
  parameter int WIN_SCORE          = 9,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POINT_PAUSE_FRAMES = 90,
  parameter int OVER_HOLD_FRAMES   = 600,
  localparam int PW = $clog2(NUM_PLAYERS)
) (
  input  logic                       clk_0,
  input  logic                       rst,
  input  logic                       frame_tick,
  input  logic                       start_trigger,
  input  logic [1:0]                 mode_choice,
  input  logic                       pause_req,
  input  logic                       point_scored,
  input  logic [PW-1:0]              point_player,
  output logic [1:0]                 mode,
  output logic [2:0]                 state,
  output logic                       game_startup,
  output logic                       serve_go,
  output logic                       rally_active,
  output logic [PW-1:0]              server,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                       game_over,
  output logic [PW-1:0]              winner
);

  // state  | meaning
  // MENU   | idle, waiting for start_trigger
  // SERVE  | serve delay running, ball parked
  // RALLY  | ball in play, waiting for a point
  // POINT  | post-point display delay
  // PAUSED | frozen; saved state and counter restored on next pause_req
  // OVER   | match won; hold before auto-return to MENU
  typedef enum logic [2:0] {
    S_MENU   = 3'd0,
    S_SERVE  = 3'd1,
    S_RALLY  = 3'd2,
    S_POINT  = 3'd3,
    S_PAUSED = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] WIN_T      = SCORE_W'(WIN_SCORE);
  localparam logic [9:0]         SERVE_LAST = 10'(SERVE_DELAY_FRAMES - 1);
  localparam logic [9:0]         POINT_LAST = 10'(POINT_PAUSE_FRAMES - 1);
  localparam logic [9:0]         OVER_LAST  = 10'(OVER_HOLD_FRAMES - 1);

  state_t               state_q, state_d, saved_state_q, saved_state_d;
  logic [9:0]           cnt_q, cnt_d, saved_cnt_q, saved_cnt_d;
  logic [SCORE_W-1:0]   score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]   score_d [NUM_PLAYERS];
  logic [PW-1:0]        server_q, server_d, winner_q, winner_d;
  logic [1:0]           mode_q, mode_d;
  logic                 serve_go_q, serve_go_d;
  logic                 startup_q, rally_q, over_q;

  logic                 pt_valid;
  logic                 pt_win;
  logic [SCORE_W-1:0]   pt_cur;
  logic [SCORE_W-1:0]   pt_score;
`ifdef WIN_BY_TWO_EN
  logic                 margin_ok;
  logic                 lead;
`endif

  // Score the point would produce and whether it ends the match.
  always_comb begin
    pt_valid = 32'(point_player) < NUM_PLAYERS;
    pt_cur   = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (point_player == PW'(i)) pt_cur = score_q[i];
    pt_score = (pt_cur == SCORE_MAX) ? pt_cur : pt_cur + 1'b1;
`ifdef WIN_BY_TWO_EN
    margin_ok = 1'b1;
    lead      = 1'b1;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (point_player != PW'(i)) begin
        if ({1'b0, pt_score} < {1'b0, score_q[i]} + (SCORE_W+1)'(2)) margin_ok = 1'b0;
        if (pt_score <= score_q[i]) lead = 1'b0;
      end
    end
    pt_win = ((pt_score >= WIN_T) && margin_ok) || ((pt_score == SCORE_MAX) && lead);
`else
    pt_win = pt_score >= WIN_T;
`endif
  end

  always_comb begin
    state_d       = state_q;
    saved_state_d = saved_state_q;
    saved_cnt_d   = saved_cnt_q;
    cnt_d         = (frame_tick && state_q != S_PAUSED) ? cnt_q + 10'd1 : cnt_q;
    score_d       = score_q;
    server_d      = server_q;
    winner_d      = winner_q;
    mode_d        = mode_q;
    serve_go_d    = 1'b0;
    case (state_q)
      S_MENU: if (start_trigger) begin
        mode_d = mode_choice;
        for (int i = 0; i < NUM_PLAYERS; i++) score_d[i] = '0;
        server_d = '0;
        winner_d = '0;
        state_d  = S_SERVE;
      end
      S_SERVE: begin
        if (pause_req) begin
          saved_state_d = S_SERVE;
          saved_cnt_d   = cnt_q;
          state_d       = S_PAUSED;
        end else if (frame_tick && cnt_q == SERVE_LAST) begin
          state_d    = S_RALLY;
          serve_go_d = 1'b1;
        end
      end
      S_RALLY: begin
        if (point_scored && pt_valid) begin
          for (int i = 0; i < NUM_PLAYERS; i++)
            if (point_player == PW'(i)) score_d[i] = pt_score;
          server_d = point_player;
          if (pt_win) begin
            winner_d = point_player;
            state_d  = S_OVER;
          end else begin
            state_d = S_POINT;
          end
        end else if (pause_req) begin
          saved_state_d = S_RALLY;
          saved_cnt_d   = cnt_q;
          state_d       = S_PAUSED;
        end
      end
      S_POINT: begin
        if (pause_req) begin
          saved_state_d = S_POINT;
          saved_cnt_d   = cnt_q;
          state_d       = S_PAUSED;
        end else if (frame_tick && cnt_q == POINT_LAST) begin
          state_d = S_SERVE;
        end
      end
      S_PAUSED: if (pause_req) begin
        state_d = saved_state_q;
        cnt_d   = saved_cnt_q;
      end
      S_OVER: if (start_trigger || (frame_tick && cnt_q == OVER_LAST)) state_d = S_MENU;
      default: state_d = S_MENU;
    endcase
    // Leaving PAUSED restores the saved count instead of clearing it.
    if (state_d != state_q && state_q != S_PAUSED) cnt_d = '0;
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state_q       <= S_MENU;
      saved_state_q <= S_MENU;
      cnt_q         <= '0;
      saved_cnt_q   <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
      server_q      <= '0;
      winner_q      <= '0;
      mode_q        <= '0;
      serve_go_q    <= 1'b0;
      startup_q     <= 1'b1;
      rally_q       <= 1'b0;
      over_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      saved_state_q <= saved_state_d;
      cnt_q         <= cnt_d;
      saved_cnt_q   <= saved_cnt_d;
      score_q       <= score_d;
      server_q      <= server_d;
      winner_q      <= winner_d;
      mode_q        <= mode_d;
      serve_go_q    <= serve_go_d;
      startup_q     <= (state_d == S_MENU);
      rally_q       <= (state_d == S_RALLY);
      over_q        <= (state_d == S_OVER);
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_scores
    assign scores[g*SCORE_W +: SCORE_W] = score_q[g];
  end

  assign state        = state_q;
  assign mode         = mode_q;
  assign game_startup = startup_q;
  assign serve_go     = serve_go_q;
  assign rally_active = rally_q;
  assign server       = server_q;
  assign game_over    = over_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_pong_match_fsm.sv
// Bench for pong_match_fsm: timer-based reference model compared every cycle,
// plus directed literal checks of the match flow.
module tb_pong_match_fsm;
  localparam int NP = 3, SW = 4, WIN = 9, SD = 60, PP = 90, OH = 600;
  localparam int PW = 2, MAXS = 15;

  logic clk_0 = 1'b0, rst = 1'b0;
  logic frame_tick = 1'b0, start_trigger = 1'b0, pause_req = 1'b0, point_scored = 1'b0;
  logic [1:0] mode_choice = 2'd0;
  logic [PW-1:0] point_player = '0;
  logic [1:0] mode;
  logic [2:0] state;
  logic game_startup, serve_go, rally_active, game_over;
  logic [PW-1:0] server, winner;
  logic [NP*SW-1:0] scores;

  int checks = 0, errors = 0, serve_go_seen = 0;

  pong_match_fsm #(
    .NUM_PLAYERS(NP), .SCORE_W(SW), .WIN_SCORE(WIN),
    .SERVE_DELAY_FRAMES(SD), .POINT_PAUSE_FRAMES(PP), .OVER_HOLD_FRAMES(OH)
  ) dut (
    .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick), .start_trigger(start_trigger),
    .mode_choice(mode_choice), .pause_req(pause_req), .point_scored(point_scored),
    .point_player(point_player), .mode(mode), .state(state), .game_startup(game_startup),
    .serve_go(serve_go), .rally_active(rally_active), .server(server), .scores(scores),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk_0 = ~clk_0;

  // Reference model: phases as small integers, timers count remaining frames down.
  int m_state = 0, m_left = 0, m_saved_state = 0, m_saved_left = 0;
  int m_mode = 0, m_server = 0, m_winner = 0;
  int m_score [NP] = '{default: 0};
  bit m_go = 0;

  function automatic bit wins(int p, int s);
    int best = 0;
    for (int i = 0; i < NP; i++) if (i != p && m_score[i] > best) best = m_score[i];
`ifdef WIN_BY_TWO_EN
    return (s >= WIN && s >= best + 2) || (s == MAXS && s > best);
`else
    return s >= WIN;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_left = 0; m_saved_state = 0; m_saved_left = 0;
    m_mode = 0; m_server = 0; m_winner = 0; m_go = 0;
    for (int i = 0; i < NP; i++) m_score[i] = 0;
  endtask

  task automatic go_pause();
    m_saved_state = m_state; m_saved_left = m_left; m_state = 4;
  endtask

  task automatic model_step();
    int p, s;
    m_go = 0;
    case (m_state)
      0: if (start_trigger) begin
        m_mode = int'(mode_choice); m_server = 0; m_winner = 0;
        for (int i = 0; i < NP; i++) m_score[i] = 0;
        m_state = 1; m_left = SD;
      end
      1: if (pause_req) go_pause();
         else if (frame_tick) begin
           m_left--;
           if (m_left == 0) begin m_state = 2; m_go = 1; end
         end
      2: begin
        p = int'(point_player);
        if (point_scored && p < NP) begin
          s = (m_score[p] < MAXS) ? m_score[p] + 1 : MAXS;
          m_score[p] = s; m_server = p;
          if (wins(p, s)) begin m_state = 5; m_winner = p; m_left = OH; end
          else begin m_state = 3; m_left = PP; end
        end else if (pause_req) go_pause();
      end
      3: if (pause_req) go_pause();
         else if (frame_tick) begin
           m_left--;
           if (m_left == 0) begin m_state = 1; m_left = SD; end
         end
      4: if (pause_req) begin m_state = m_saved_state; m_left = m_saved_left; end
      5: if (start_trigger) m_state = 0;
         else if (frame_tick) begin
           m_left--;
           if (m_left == 0) m_state = 0;
         end
      default: m_state = 0;
    endcase
  endtask

  always @(posedge clk_0 or negedge rst) begin
    if (!rst) model_reset();
    else model_step();
  end

  task automatic compare_model();
    logic [NP*SW-1:0] exp_sc;
    for (int i = 0; i < NP; i++) exp_sc[i*SW +: SW] = SW'(m_score[i]);
    checks++;
    if (state !== 3'(m_state) || mode !== 2'(m_mode) || game_startup !== (m_state == 0) ||
        serve_go !== m_go || rally_active !== (m_state == 2) || game_over !== (m_state == 5) ||
        server !== PW'(m_server) || winner !== PW'(m_winner) || scores !== exp_sc) begin
      errors++;
      $display("FAIL model_cmp t=%0t state %0d/%0d mode %0d/%0d go %0b/%0b srv %0d/%0d win %0d/%0d scores %h/%h",
               $time, state, m_state, mode, m_mode, serve_go, m_go, server, m_server,
               winner, m_winner, scores, exp_sc);
    end
    if (serve_go) serve_go_seen++;
  endtask

  task automatic lit(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic cyc();
    @(negedge clk_0);
    compare_model();
  endtask

  task automatic tick(int n);
    repeat (n) begin
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b0; cyc();
    end
  endtask

  task automatic start(int m);
    mode_choice = 2'(m); start_trigger = 1'b1; cyc();
    start_trigger = 1'b0; cyc();
  endtask

  task automatic point(int p, bit with_pause);
    point_scored = 1'b1; point_player = PW'(p); pause_req = with_pause; cyc();
    point_scored = 1'b0; pause_req = 1'b0; cyc();
  endtask

  task automatic pause_pulse();
    pause_req = 1'b1; cyc();
    pause_req = 1'b0; cyc();
  endtask

  task automatic play_point(int p);
    point(p, 1'b0);
    if (m_state == 3) begin tick(PP); tick(SD); end
  endtask

  initial begin
    cyc(); cyc();
    lit("reset_state", int'(state), 0);
    lit("reset_startup", int'(game_startup), 1);
    lit("reset_scores", int'(scores), 0);
    rst = 1'b1;
    cyc();

    start(2);
    lit("start_mode", int'(mode), 2);
    lit("start_serve", int'(state), 1);
    tick(SD - 1);
    lit("serve_wait", int'(state), 1);
    lit("no_early_go", serve_go_seen, 0);
    tick(1);
    lit("one_serve_go", serve_go_seen, 1);
    lit("rally_state", int'(state), 2);
    lit("rally_active", int'(rally_active), 1);

    point(3, 1'b0);
    lit("bad_player_state", int'(state), 2);
    lit("bad_player_scores", int'(scores), 0);

    point(0, 1'b1);
    lit("pt_over_pause_score", int'(scores[3:0]), 1);
    lit("pt_over_pause_state", int'(state), 3);

    tick(40);
    pause_pulse();
    lit("paused", int'(state), 4);
    tick(100);
    lit("still_paused", int'(state), 4);
    pause_pulse();
    lit("resumed_point", int'(state), 3);
    tick(49);
    lit("point_hold", int'(state), 3);
    tick(1);
    lit("point_to_serve", int'(state), 1);

    tick(SD);
    for (int k = 0; k < 9; k++) play_point(1);
    lit("p1_score", int'(scores[7:4]), 9);
    lit("p1_game_over", int'(game_over), 1);
    lit("p1_winner", int'(winner), 1);
    lit("p1_over_state", int'(state), 5);
    lit("p1_server", int'(server), 1);
    pause_pulse();
    lit("pause_in_over", int'(state), 5);

    start(0);
    lit("over_to_menu", int'(state), 0);
    lit("scores_held", int'(scores[7:4]), 9);
    start(1);
    lit("scores_cleared", int'(scores), 0);
    lit("mode1", int'(mode), 1);

    tick(SD);
    for (int k = 0; k < 8; k++) begin play_point(0); play_point(1); end
    lit("tied_8_8", int'(scores), 12'h088);
    point(0, 1'b0);
`ifdef WIN_BY_TWO_EN
    lit("by_two_9_8_point", int'(state), 3);
    tick(PP); tick(SD);
    point(0, 1'b0);
    lit("by_two_score", int'(scores[3:0]), 10);
`else
    lit("first_to_9", int'(scores[3:0]), 9);
`endif
    lit("p0_over", int'(state), 5);
    lit("p0_winner", int'(winner), 0);
    tick(OH - 1);
    lit("over_hold", int'(state), 5);
    tick(1);
    lit("over_auto_menu", int'(state), 0);

    start(3);
    tick(SD);
    play_point(2);
    lit("pre_reset_rally", int'(state), 2);
    @(posedge clk_0);
    #1 rst = 1'b0;
    #1;
    lit("async_rst_state", int'(state), 0);
    lit("async_rst_scores", int'(scores), 0);
    lit("async_rst_startup", int'(game_startup), 1);
    lit("async_rst_go", int'(serve_go), 0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    lit("post_reset_menu", int'(state), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
